// File: rtl/f_bpredict.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit counters, for a 2-wide front end.
// Latency: predictions are combinational from pc and the table; pc and the table update on the next edge.
// Backpressure: stall holds pc and a redirect overrides stall; training does not depend on either.
module f_bpredict #(
    parameter int          PC_W     = 13,
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            fail_predict,
    input  logic [PC_W-1:0] true_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic [PC_W-1:0] pc,
    output logic            slot1_valid,
    output logic [PC_W-1:0] pc_predicted1,
    output logic [PC_W-1:0] pc_predicted2,
    output logic [1:0]      pred_taken
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic [PC_W-1:0]    r_pc;
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [PC_W-1:0]    r_tgt [ENTRIES];
    logic [1:0]         r_ctr [ENTRIES];

    logic [PC_W-1:0]  w_pc_b;
    logic [PC_W-1:0]  w_pc_2;
    logic [IDX_W-1:0] w_idx_a;
    logic [IDX_W-1:0] w_idx_b;
    logic [IDX_W-1:0] w_idx_u;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_hit_u;
    logic             w_tk_a;
    logic             w_tk_b;
    logic [PC_W-1:0]  w_next_pc;
    logic [1:0]       w_ctr_nxt;

    // Slot 1 and the fall-through PC; wrap modulo 2**PC_W comes from the width.
    assign w_pc_b  = r_pc + PC_W'(1);
    assign w_pc_2  = r_pc + PC_W'(2);
    assign w_idx_a = r_pc[IDX_W-1:0];
    assign w_idx_b = w_pc_b[IDX_W-1:0];
    assign w_idx_u = upd_pc[IDX_W-1:0];

    // Lookup for both fetch slots plus the training port.
    assign w_hit_a = r_valid[w_idx_a] && (r_tag[w_idx_a] == r_pc[PC_W-1:IDX_W]);
    assign w_hit_b = r_valid[w_idx_b] && (r_tag[w_idx_b] == w_pc_b[PC_W-1:IDX_W]);
    assign w_hit_u = r_valid[w_idx_u] && (r_tag[w_idx_u] == upd_pc[PC_W-1:IDX_W]);
    assign w_tk_a  = w_hit_a && r_ctr[w_idx_a][1];
    assign w_tk_b  = w_hit_b && r_ctr[w_idx_b][1];

    assign pc            = r_pc;
    assign pc_predicted1 = w_tk_a ? r_tgt[w_idx_a] : w_pc_b;
    assign pc_predicted2 = w_tk_b ? r_tgt[w_idx_b] : w_pc_2;
    assign pred_taken    = {w_tk_b & ~w_tk_a, w_tk_a};
    assign slot1_valid   = ~w_tk_a;
    assign w_next_pc     = w_tk_a ? r_tgt[w_idx_a] : (w_tk_b ? r_tgt[w_idx_b] : w_pc_2);

    // Saturating counter step for a hit on the training port.
    always_comb begin
        w_ctr_nxt = r_ctr[w_idx_u];
        if (upd_taken) begin
            if (r_ctr[w_idx_u] != 2'b11) w_ctr_nxt = r_ctr[w_idx_u] + 2'b01;
        end else begin
            if (r_ctr[w_idx_u] != 2'b00) w_ctr_nxt = r_ctr[w_idx_u] - 2'b01;
        end
    end

    // Fetch PC: a redirect beats stall, otherwise follow the prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (fail_predict) begin
            r_pc <= true_pc;
        end else if (!stall) begin
            r_pc <= w_next_pc;
        end
    end

    // BTB training: update on hit, allocate on a taken miss, ignore a not-taken miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_tgt[i] <= '0;
                r_ctr[i] <= '0;
            end
        end else if (upd_valid) begin
            if (w_hit_u) begin
                r_ctr[w_idx_u] <= w_ctr_nxt;
                if (upd_taken) r_tgt[w_idx_u] <= upd_target;
            end else if (upd_taken) begin
                r_valid[w_idx_u] <= 1'b1;
                r_tag[w_idx_u]   <= upd_pc[PC_W-1:IDX_W];
                r_tgt[w_idx_u]   <= upd_target;
                r_ctr[w_idx_u]   <= CTR_INIT;
            end
        end
    end
endmodule

// File: tb/tb_f_bpredict.sv
// Directed bench for f_bpredict: reset, sequential fetch, taken prediction, counters, redirect, wrap, alias.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after async reset.
// Each scenario task does its own comparisons against hand-computed values.
module tb_f_bpredict;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fail_predict;
    logic [12:0] true_pc;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic        upd_taken;
    logic [12:0] upd_target;
    logic [12:0] pc;
    logic        slot1_valid;
    logic [12:0] pc_predicted1;
    logic [12:0] pc_predicted2;
    logic [1:0]  pred_taken;

    int checks = 0;
    int errors = 0;

    f_bpredict dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .fail_predict(fail_predict), .true_pc(true_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .pc(pc), .slot1_valid(slot1_valid), .pc_predicted1(pc_predicted1),
        .pc_predicted2(pc_predicted2), .pred_taken(pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full cycle, negedge to negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [12:0] p);
        fail_predict = 1'b1;
        true_pc = p;
        step();
        fail_predict = 1'b0;
    endtask

    task automatic upd(input logic [12:0] p, input logic t, input logic [12:0] tg);
        upd_valid = 1'b1;
        upd_pc = p;
        upd_taken = t;
        upd_target = tg;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 13'h0000); end
        checks++; if (pc_predicted1 !== 13'h0001) begin errors++; $display("FAIL reset_pp1: got %h want %h", pc_predicted1, 13'h0001); end
        checks++; if (pc_predicted2 !== 13'h0002) begin errors++; $display("FAIL reset_pp2: got %h want %h", pc_predicted2, 13'h0002); end
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL reset_pt: got %b want %b", pred_taken, 2'b00); end
        checks++; if (slot1_valid !== 1'b1) begin errors++; $display("FAIL reset_s1v: got %b want %b", slot1_valid, 1'b1); end
    endtask

    task automatic test_sequential();
        logic [12:0] exp;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 13'(2 * i);
            checks++; if (pc !== exp) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp); end
            checks++; if (pc_predicted1 !== exp + 13'd1) begin errors++; $display("FAIL seq_pp1_%0d: got %h want %h", i, pc_predicted1, exp + 13'd1); end
            checks++; if (pc_predicted2 !== exp + 13'd2) begin errors++; $display("FAIL seq_pp2_%0d: got %h want %h", i, pc_predicted2, exp + 13'd2); end
            step();
        end
    endtask

    task automatic test_taken();
        stall = 1'b1;
        do_reset();
        redirect(13'h010);
        // Write in flight to the fetched index: lookup still sees the old (empty) entry.
        upd_valid = 1'b1; upd_pc = 13'h010; upd_taken = 1'b1; upd_target = 13'h040;
        #1;
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t2_same_cycle_pt: got %b want %b", pred_taken, 2'b00); end
        step();
        upd_valid = 1'b0;
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t2_pt: got %b want %b", pred_taken, 2'b01); end
        checks++; if (slot1_valid !== 1'b0) begin errors++; $display("FAIL t2_s1v: got %b want %b", slot1_valid, 1'b0); end
        checks++; if (pc_predicted1 !== 13'h040) begin errors++; $display("FAIL t2_pp1: got %h want %h", pc_predicted1, 13'h040); end
        checks++; if (pc_predicted2 !== 13'h012) begin errors++; $display("FAIL t2_pp2: got %h want %h", pc_predicted2, 13'h012); end
        stall = 1'b0;
        step();
        stall = 1'b1;
        checks++; if (pc !== 13'h040) begin errors++; $display("FAIL t2_next_pc: got %h want %h", pc, 13'h040); end
        // Slot 1 taken instead.
        do_reset();
        upd(13'h011, 1'b1, 13'h040);
        redirect(13'h010);
        checks++; if (pred_taken !== 2'b10) begin errors++; $display("FAIL t2b_pt: got %b want %b", pred_taken, 2'b10); end
        checks++; if (slot1_valid !== 1'b1) begin errors++; $display("FAIL t2b_s1v: got %b want %b", slot1_valid, 1'b1); end
        checks++; if (pc_predicted1 !== 13'h011) begin errors++; $display("FAIL t2b_pp1: got %h want %h", pc_predicted1, 13'h011); end
        checks++; if (pc_predicted2 !== 13'h040) begin errors++; $display("FAIL t2b_pp2: got %h want %h", pc_predicted2, 13'h040); end
        stall = 1'b0;
        step();
        stall = 1'b1;
        checks++; if (pc !== 13'h040) begin errors++; $display("FAIL t2b_next_pc: got %h want %h", pc, 13'h040); end
    endtask

    task automatic test_counter();
        do_reset();
        redirect(13'h010);
        upd(13'h010, 1'b1, 13'h040);                 // alloc -> 10
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t3_alloc_pt: got %b want %b", pred_taken, 2'b01); end
        upd(13'h010, 1'b0, 13'h0AA);                 // 01
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t3_nt1_pt: got %b want %b", pred_taken, 2'b00); end
        checks++; if (pc_predicted1 !== 13'h011) begin errors++; $display("FAIL t3_nt1_pp1: got %h want %h", pc_predicted1, 13'h011); end
        for (int i = 0; i < 3; i++) upd(13'h010, 1'b1, 13'h060);   // 10, 11, 11
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t3_t3_pt: got %b want %b", pred_taken, 2'b01); end
        checks++; if (pc_predicted1 !== 13'h060) begin errors++; $display("FAIL t3_t3_pp1: got %h want %h", pc_predicted1, 13'h060); end
        upd(13'h010, 1'b0, 13'h0AA);                 // 10, target kept
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t3_sat11_pt: got %b want %b", pred_taken, 2'b01); end
        checks++; if (pc_predicted1 !== 13'h060) begin errors++; $display("FAIL t3_nt_tgt: got %h want %h", pc_predicted1, 13'h060); end
        for (int i = 0; i < 3; i++) upd(13'h010, 1'b0, 13'h0AA);   // 01, 00, 00
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t3_nt4_pt: got %b want %b", pred_taken, 2'b00); end
        upd(13'h010, 1'b1, 13'h060);                 // 01
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t3_sat00_pt: got %b want %b", pred_taken, 2'b00); end
        upd(13'h010, 1'b1, 13'h060);                 // 10
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t3_retake_pt: got %b want %b", pred_taken, 2'b01); end
        upd(13'h020, 1'b0, 13'h070);                 // not-taken miss: no write
        redirect(13'h020);
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t3_ntmiss_pt: got %b want %b", pred_taken, 2'b00); end
        checks++; if (pc_predicted1 !== 13'h021) begin errors++; $display("FAIL t3_ntmiss_pp1: got %h want %h", pc_predicted1, 13'h021); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        redirect(13'h123);
        checks++; if (pc !== 13'h123) begin errors++; $display("FAIL t4_redirect: got %h want %h", pc, 13'h123); end
        step();
        step();
        checks++; if (pc !== 13'h123) begin errors++; $display("FAIL t4_stall_hold: got %h want %h", pc, 13'h123); end
        stall = 1'b0;
        redirect(13'h0AB);
        stall = 1'b1;
        checks++; if (pc !== 13'h0AB) begin errors++; $display("FAIL t4_redirect_nostall: got %h want %h", pc, 13'h0AB); end
    endtask

    task automatic test_wrap_alias();
        stall = 1'b1;
        do_reset();
        redirect(13'h1FFF);
        checks++; if (pc_predicted1 !== 13'h0000) begin errors++; $display("FAIL t5_pp1: got %h want %h", pc_predicted1, 13'h0000); end
        checks++; if (pc_predicted2 !== 13'h0001) begin errors++; $display("FAIL t5_pp2: got %h want %h", pc_predicted2, 13'h0001); end
        stall = 1'b0;
        step();
        stall = 1'b1;
        checks++; if (pc !== 13'h0001) begin errors++; $display("FAIL t5_next_pc: got %h want %h", pc, 13'h0001); end
        upd(13'h0000, 1'b1, 13'h0AB);
        redirect(13'h1FFF);
        checks++; if (pred_taken !== 2'b10) begin errors++; $display("FAIL t5_wrap_pt: got %b want %b", pred_taken, 2'b10); end
        checks++; if (pc_predicted2 !== 13'h0AB) begin errors++; $display("FAIL t5_wrap_pp2: got %h want %h", pc_predicted2, 13'h0AB); end
        upd(13'h010, 1'b1, 13'h040);
        upd(13'h050, 1'b1, 13'h077);
        redirect(13'h010);
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t5_alias_pt: got %b want %b", pred_taken, 2'b00); end
        checks++; if (pc_predicted1 !== 13'h011) begin errors++; $display("FAIL t5_alias_pp1: got %h want %h", pc_predicted1, 13'h011); end
        redirect(13'h050);
        checks++; if (pc_predicted1 !== 13'h077) begin errors++; $display("FAIL t5_alias_new: got %h want %h", pc_predicted1, 13'h077); end
    endtask

    task automatic test_async_reset();
        stall = 1'b0;
        upd(13'h010, 1'b1, 13'h040);
        redirect(13'h010);
        checks++; if (pred_taken !== 2'b01) begin errors++; $display("FAIL t6_pre_pt: got %b want %b", pred_taken, 2'b01); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL t6_pc: got %h want %h", pc, 13'h0000); end
        checks++; if (pc_predicted1 !== 13'h0001) begin errors++; $display("FAIL t6_pp1: got %h want %h", pc_predicted1, 13'h0001); end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b1;
        redirect(13'h010);
        checks++; if (pred_taken !== 2'b00) begin errors++; $display("FAIL t6_cleared_pt: got %b want %b", pred_taken, 2'b00); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; fail_predict = 1'b0; true_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        test_reset();
        test_sequential();
        test_taken();
        test_counter();
        test_redirect_stall();
        test_wrap_alias();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
